// File: rtl/sum_accumulator_pkg.sv
// Shared types and helpers for the sum accumulator.
package sum_accum_pkg;

   // ACCUM: collecting beats, no result pending. HOLD: result presented on the output.
   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   // Bits needed to hold a beat count in the range 0..n.
   function automatic int clog2p1(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/sum_accumulator_if.sv
// Input sum stream and output group-result stream of the sum accumulator.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. A producer holds valid and its payload stable until that edge and
// never waits for ready before raising valid; ready may depend combinationally
// on the other side's state. flush is a single-cycle sideband pulse qualified
// only by itself, not by in_valid.
interface sum_accumulator_if #(
   parameter int WIDTH = 8,
   parameter int ACC_W = 10,
   parameter int CNT_W = 3
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_data;
   logic [CNT_W-1:0] out_count;
   logic             out_ovf;

   // Upstream adder / downstream reader side.
   modport master (
      output in_valid, in_data, flush, out_ready,
      input  in_ready, out_valid, out_data, out_count, out_ovf
   );

   // Accumulator side.
   modport slave (
      input  in_valid, in_data, flush, out_ready,
      output in_ready, out_valid, out_data, out_count, out_ovf
   );
endinterface

// File: rtl/sum_accumulator.sv
// Accumulates groups of COUNT sums (or shorter groups closed by flush) into a
// wider total, with a sticky carry-out flag, and holds each group result until
// the downstream stage takes it.
module sum_accumulator
   import sum_accum_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int COUNT = 4,
   parameter int ACC_W = WIDTH + $clog2(COUNT)
) (
   input  logic             clk,
   input  logic             rst_n,
   sum_accumulator_if.slave bus,
   output state_t           state
);

   localparam int CNT_W = clog2p1(COUNT);

   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             ovf;

   logic             accept;
   logic [ACC_W:0]   sum;
   logic [ACC_W-1:0] nxt_acc;
   logic [CNT_W-1:0] nxt_cnt;
   logic             nxt_ovf;
   logic             close;

   // A pending result blocks input unless it retires this same cycle.
   assign bus.in_ready = !bus.out_valid || bus.out_ready;

   // Next group state after this cycle's beat, and whether the group closes.
   // acc/cnt are already zero while a result is held, so a beat taken on the
   // retiring cycle naturally starts a fresh group.
   always_comb begin
      accept  = bus.in_valid && bus.in_ready;
      sum     = {1'b0, acc} + (ACC_W + 1)'(bus.in_data);
      nxt_acc = acc;
      nxt_cnt = cnt;
      nxt_ovf = ovf;
      if (accept) begin
         nxt_acc = sum[ACC_W-1:0];
         nxt_cnt = cnt + CNT_W'(1);
         nxt_ovf = ovf | sum[ACC_W];
      end
      close = (accept && (nxt_cnt == CNT_W'(COUNT))) ||
              (bus.flush && ((cnt != '0) || accept));
   end

   // Accumulator, FSM and output holding register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc           <= '0;
         cnt           <= '0;
         ovf           <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_count <= '0;
         bus.out_ovf   <= 1'b0;
         state         <= ACCUM;
      end else if (close) begin
         bus.out_valid <= 1'b1;
         bus.out_data  <= nxt_acc;
         bus.out_count <= nxt_cnt;
         bus.out_ovf   <= nxt_ovf;
         acc           <= '0;
         cnt           <= '0;
         ovf           <= 1'b0;
         state         <= HOLD;
      end else begin
         acc <= nxt_acc;
         cnt <= nxt_cnt;
         ovf <= nxt_ovf;
         if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= ACCUM;
         end
      end
   end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: default build plus ACC_W=9 and COUNT=1 builds.
module tb_sum_accumulator;
   import sum_accum_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst_n;
   int   cyc;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUTs ----------------
   sum_accumulator_if #(.WIDTH(8), .ACC_W(10), .CNT_W(3)) a_if ();
   sum_accumulator_if #(.WIDTH(8), .ACC_W(9),  .CNT_W(3)) b_if ();
   sum_accumulator_if #(.WIDTH(8), .ACC_W(8),  .CNT_W(1)) c_if ();
   state_t a_state, b_state, c_state;

   sum_accumulator #(.WIDTH(8), .COUNT(4), .ACC_W(10)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(a_if.slave), .state(a_state));
   sum_accumulator #(.WIDTH(8), .COUNT(4), .ACC_W(9)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(b_if.slave), .state(b_state));
   sum_accumulator #(.WIDTH(8), .COUNT(1), .ACC_W(8)) dut_c (
      .clk(clk), .rst_n(rst_n), .bus(c_if.slave), .state(c_state));

   // ---------------- checking ----------------
   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- scoreboard for dut_a ----------------
   // packed as {data[9:0], count[2:0], ovf}
   logic [13:0] exp_q[$];

   task automatic push_exp(input logic [9:0] d, input logic [2:0] c, input logic o);
      exp_q.push_back({d, c, o});
   endtask

   always @(negedge clk) begin
      logic [13:0] e;
      if (rst_n && a_if.out_valid && a_if.out_ready) begin
         if (exp_q.size() == 0) begin
            chk("exp_q_size", 32'(exp_q.size()), 1);
         end else begin
            e = exp_q.pop_front();
            chk("res_data",  32'(a_if.out_data),  32'(e[13:4]));
            chk("res_count", 32'(a_if.out_count), 32'(e[3:1]));
            chk("res_ovf",   32'(a_if.out_ovf),   32'(e[0]));
         end
      end
   end

   // ---------------- driver tasks (dut_a) ----------------
   // Present one beat (optionally with flush) and return just after the edge that takes it.
   task automatic send(input logic [7:0] d, input logic fl);
      int n;
      n = 0;
      a_if.in_valid = 1'b1;
      a_if.in_data  = d;
      a_if.flush    = fl;
      @(negedge clk);
      while (!a_if.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!a_if.in_ready) chk("send_timeout", 32'(a_if.in_ready), 1);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      a_if.in_valid = 1'b0;
      a_if.flush    = 1'b0;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int start;
      logic [7:0] c_beats [3];
      c_beats = '{8'd3, 8'd200, 8'd17};
      cyc   = 0;
      rst_n = 1'b0;
      a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.flush = 1'b0; a_if.out_ready = 1'b1;
      b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.flush = 1'b0; b_if.out_ready = 1'b1;
      c_if.in_valid = 1'b0; c_if.in_data = '0; c_if.flush = 1'b0; c_if.out_ready = 1'b1;
      step(3);
      chk("rst_out_valid", 32'(a_if.out_valid), 0);
      chk("rst_out_data",  32'(a_if.out_data), 0);
      chk("rst_in_ready",  32'(a_if.in_ready), 1);
      chk("rst_state",     32'(a_state), 32'(ACCUM));
      rst_n = 1'b1;
      step(1);

      // 1: reset mid-group, then 1+2+3+4
      send(8'd1, 1'b0);
      send(8'd2, 1'b0);
      idle();
      #2 rst_n = 1'b0;
      #1 chk("midgrp_rst_valid", 32'(a_if.out_valid), 0);
      step(2);
      rst_n = 1'b1;
      step(1);
      push_exp(10'd10, 3'd4, 1'b0);
      send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b0); send(8'd4, 1'b0);
      idle();
      chk("t1_latency_valid", 32'(a_if.out_valid), 1);
      chk("t1_state_hold",    32'(a_state), 32'(HOLD));
      step(3);

      // 2: four beats of 255, no wrap at ACC_W=10
      push_exp(10'd1020, 3'd4, 1'b0);
      repeat (4) send(8'd255, 1'b0);
      idle();
      step(3);

      // 2b: ACC_W=9 wraps and flags overflow; sticky flag clears for next group
      for (int i = 0; i < 4; i++) begin
         b_if.in_valid = 1'b1; b_if.in_data = 8'd255;
         step(1);
      end
      b_if.in_valid = 1'b0;
      chk("w9_valid", 32'(b_if.out_valid), 1);
      chk("w9_data",  32'(b_if.out_data), 508);
      chk("w9_count", 32'(b_if.out_count), 4);
      chk("w9_ovf",   32'(b_if.out_ovf), 1);
      step(1);
      for (int i = 0; i < 4; i++) begin
         b_if.in_valid = 1'b1; b_if.in_data = 8'd1;
         step(1);
      end
      b_if.in_valid = 1'b0;
      chk("w9_data2", 32'(b_if.out_data), 4);
      chk("w9_ovf2",  32'(b_if.out_ovf), 0);
      step(2);

      // 3: result held with out_ready=0; beat and flush attempts ignored
      a_if.out_ready = 1'b0;
      push_exp(10'd26, 3'd4, 1'b0);
      send(8'd5, 1'b0); send(8'd6, 1'b0); send(8'd7, 1'b0); send(8'd8, 1'b0);
      a_if.in_valid = 1'b1; a_if.in_data = 8'd99; a_if.flush = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_valid",    32'(a_if.out_valid), 1);
         chk("hold_data",     32'(a_if.out_data), 26);
         chk("hold_in_ready", 32'(a_if.in_ready), 0);
      end
      step(1);
      idle();
      a_if.out_ready = 1'b1;
      step(1);
      chk("retire_valid", 32'(a_if.out_valid), 0);
      step(2);
      chk("hold_ignored_valid", 32'(a_if.out_valid), 0);

      // 4: flush-only close, lone flush, flush with a beat
      push_exp(10'd16, 3'd2, 1'b0);
      send(8'd7, 1'b0); send(8'd9, 1'b0);
      a_if.in_valid = 1'b0; a_if.flush = 1'b1;
      step(1);
      a_if.flush = 1'b0;
      chk("flush_latency_valid", 32'(a_if.out_valid), 1);
      step(2);
      a_if.flush = 1'b1;
      step(1);
      a_if.flush = 1'b0;
      chk("lone_flush_valid0", 32'(a_if.out_valid), 0);
      step(1);
      chk("lone_flush_valid1", 32'(a_if.out_valid), 0);
      push_exp(10'd21, 3'd3, 1'b0);
      send(8'd7, 1'b0); send(8'd9, 1'b0); send(8'd5, 1'b1);
      idle();
      chk("flush_beat_valid", 32'(a_if.out_valid), 1);
      step(2);

      // 5: continuous streaming, 12 beats in 12 cycles
      push_exp(10'd10, 3'd4, 1'b0);
      push_exp(10'd26, 3'd4, 1'b0);
      push_exp(10'd42, 3'd4, 1'b0);
      start = cyc;
      for (int i = 1; i <= 12; i++) send(8'(i), 1'b0);
      idle();
      chk("stream_cycles", 32'(cyc - start), 12);
      step(3);
      chk("exp_q_drained", 32'(exp_q.size()), 0);

      // 5b: COUNT=1, every beat is its own result one cycle later
      for (int i = 0; i < 3; i++) begin
         c_if.in_valid = 1'b1; c_if.in_data = c_beats[i];
         step(1);
         chk("c1_valid", 32'(c_if.out_valid), 1);
         chk("c1_data",  32'(c_if.out_data), 32'(c_beats[i]));
         chk("c1_count", 32'(c_if.out_count), 1);
      end
      c_if.in_valid = 1'b0;
      step(1);
      chk("c1_idle_valid", 32'(c_if.out_valid), 0);

      // 6: asynchronous reset while a result is pending
      a_if.out_ready = 1'b0;
      send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b0); send(8'd4, 1'b0);
      idle();
      chk("pre_rst_valid", 32'(a_if.out_valid), 1);
      #3 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(a_if.out_valid), 0);
      chk("async_rst_data",  32'(a_if.out_data), 0);
      chk("async_rst_count", 32'(a_if.out_count), 0);
      chk("async_rst_state", 32'(a_state), 32'(ACCUM));
      a_if.out_ready = 1'b1;
      step(2);
      rst_n = 1'b1;
      step(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
